// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides, status flags,
// optional unsigned saturation for ADD/SUB and a completed-operation counter.
module alu_pipe #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic [CNT_W-1:0] ops_done
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;

  logic             adv1;
  logic             adv2;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             a_lt_b;
  logic             shift_big;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_ovf;

  // A stage may advance when its successor is empty or draining this cycle,
  // which lets a full pipeline keep streaming without bubbles.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= alu_op_e'(op);
      end
    end
  end

  // The borrow of the extended subtraction doubles as the unsigned a<b test.
  assign sum       = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff      = {1'b0, s1_a} - {1'b0, s1_b};
  assign a_lt_b    = diff[WIDTH];
  assign shift_big = |s1_b[WIDTH-1:SHW];

  always_comb begin
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_ovf    = 1'b0;
    case (s1_op)
      OP_ADD: begin
        nxt_carry  = sum[WIDTH];
        nxt_ovf    = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        nxt_result = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        nxt_carry  = a_lt_b;
        nxt_ovf    = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
        nxt_result = (SATURATE && a_lt_b) ? '0 : diff[WIDTH-1:0];
      end
      OP_AND: nxt_result = s1_a & s1_b;
      OP_OR:  nxt_result = s1_a | s1_b;
      OP_XOR: nxt_result = s1_a ^ s1_b;
      OP_SHL: nxt_result = shift_big ? '0 : (s1_a << s1_b[SHW-1:0]);
      OP_SHR: nxt_result = shift_big ? '0 : (s1_a >> s1_b[SHW-1:0]);
      OP_SLT: nxt_result = {{(WIDTH-1){1'b0}}, a_lt_b};
      default: nxt_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= nxt_result;
        carry  <= nxt_carry;
        ovf    <= nxt_ovf;
        zero   <= (nxt_result == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (out_valid && out_ready) begin
      ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a wrapping 16-bit-counter instance and a saturating 4-bit-counter
// instance share one input stream and are checked against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;

  logic        in_ready0, out_valid0, carry0, ovf0, zero0;
  logic [7:0]  result0;
  logic [15:0] ops_done0;
  logic        in_ready1, out_valid1, carry1, ovf1, zero1;
  logic [7:0]  result1;
  logic [3:0]  ops_done1;

  int nchk  = 0;
  int nfail = 0;
  int occ   = 0;
  int exp_cnt = 0;
  logic [10:0] q0[$];
  logic [10:0] q1[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .carry(carry0), .ovf(ovf0), .zero(zero0), .ops_done(ops_done0)
  );

  alu_pipe #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .carry(carry1), .ovf(ovf1), .zero(zero1), .ops_done(ops_done1)
  );

  // Reference: returns {zero, ovf, carry, result[7:0]} from plain integer arithmetic.
  function automatic logic [10:0] model(input int unsigned ai, input int unsigned bi,
                                        input int unsigned opi, input bit sat);
    int unsigned r;
    bit c, v;
    c = 1'b0;
    v = 1'b0;
    case (opi)
      0: begin
        c = (ai + bi) > 255;
        r = (ai + bi) % 256;
        v = ((ai >= 128) == (bi >= 128)) && ((r >= 128) != (ai >= 128));
        if (sat && c) r = 255;
      end
      1: begin
        c = ai < bi;
        r = (ai + 256 - bi) % 256;
        v = ((ai >= 128) != (bi >= 128)) && ((r >= 128) != (ai >= 128));
        if (sat && c) r = 0;
      end
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: r = (bi >= 8) ? 0 : ((ai << bi) % 256);
      6: r = (bi >= 8) ? 0 : (ai >> bi);
      default: r = (ai < bi) ? 1 : 0;
    endcase
    return {(r == 0), v, c, r[7:0]};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    occ = 0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    pulse_reset();
    #1;
    nchk++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin nfail++; $display("[TB] FAIL reset_out_valid got %b/%b want 0", out_valid0, out_valid1); end
    nchk++; if ({zero0, ovf0, carry0, result0} !== 11'h400) begin nfail++; $display("[TB] FAIL reset_flags got %h want 400", {zero0, ovf0, carry0, result0}); end
    nchk++; if (ops_done0 !== 16'h0 || ops_done1 !== 4'h0) begin nfail++; $display("[TB] FAIL reset_ops_done got %h/%h want 0", ops_done0, ops_done1); end
    nchk++; if (in_ready0 !== 1'b1) begin nfail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready0); end
  endtask

  // One isolated operation at a time: checks latency, flags and the counter step.
  task automatic test_directed();
    logic [7:0]  ta[3]  = '{8'hF0, 8'h05, 8'h7F};
    logic [7:0]  tb[3]  = '{8'h20, 8'h09, 8'h01};
    logic [2:0]  top[3] = '{3'd0, 3'd1, 3'd0};
    logic [10:0] e0[3]  = '{11'h110, 11'h1FC, 11'h280};
    logic [10:0] e1[3]  = '{11'h1FF, 11'h500, 11'h280};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; a = ta[i]; b = tb[i]; op = top[i];
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      nchk++; if (out_valid0 !== 1'b0) begin nfail++; $display("[TB] FAIL dir_latency1[%0d] got %b want 0", i, out_valid0); end
      @(negedge clk);
      #1;
      nchk++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin nfail++; $display("[TB] FAIL dir_latency2[%0d] got %b/%b want 1", i, out_valid0, out_valid1); end
      nchk++; if ({zero0, ovf0, carry0, result0} !== e0[i]) begin nfail++; $display("[TB] FAIL dir_wrap[%0d] got %h want %h", i, {zero0, ovf0, carry0, result0}, e0[i]); end
      nchk++; if ({zero1, ovf1, carry1, result1} !== e1[i]) begin nfail++; $display("[TB] FAIL dir_sat[%0d] got %h want %h", i, {zero1, ovf1, carry1, result1}, e1[i]); end
      @(negedge clk);
      #1;
      exp_cnt++;
      nchk++; if (ops_done0 !== exp_cnt[15:0] || out_valid0 !== 1'b0) begin nfail++; $display("[TB] FAIL dir_count[%0d] got %0d/%b want %0d/0", i, ops_done0, out_valid0, exp_cnt); end
    end
  endtask

  // All eight op codes streamed with no stall must emerge on eight consecutive cycles.
  task automatic test_back_to_back();
    logic [7:0] ta[8] = '{8'h12, 8'h50, 8'hF0, 8'h0F, 8'hAA, 8'h81, 8'h81, 8'h03};
    logic [7:0] tb[8] = '{8'h34, 8'h20, 8'h3C, 8'h30, 8'hFF, 8'h01, 8'h09, 8'h07};
    logic [10:0] e0, e1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (i < 8);
      if (i < 8) begin a = ta[i]; b = tb[i]; op = i[2:0]; end
      #1;
      nchk++; if (out_valid0 !== (i >= 2 && i <= 9)) begin nfail++; $display("[TB] FAIL b2b_valid[%0d] got %b want %b", i, out_valid0, (i >= 2 && i <= 9)); end
      nchk++; if (in_ready0 !== 1'b1) begin nfail++; $display("[TB] FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready0); end
      if (out_valid0 && out_ready && q0.size() > 0) begin
        e0 = q0.pop_front(); e1 = q1.pop_front(); exp_cnt++;
        nchk++; if ({zero0, ovf0, carry0, result0} !== e0) begin nfail++; $display("[TB] FAIL b2b_res0[%0d] got %h want %h", i, {zero0, ovf0, carry0, result0}, e0); end
        nchk++; if ({zero1, ovf1, carry1, result1} !== e1) begin nfail++; $display("[TB] FAIL b2b_res1[%0d] got %h want %h", i, {zero1, ovf1, carry1, result1}, e1); end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(model(a, b, op, 1'b0));
        q1.push_back(model(a, b, op, 1'b1));
      end
    end
    nchk++; if (q0.size() != 0 || ops_done0 !== exp_cnt[15:0]) begin nfail++; $display("[TB] FAIL b2b_drain left %0d count %0d want 0/%0d", q0.size(), ops_done0, exp_cnt); end
  endtask

  // Randomised stream; when stall_lo <= cycle < stall_hi the consumer refuses results.
  task automatic run_stream(input int ncyc, input int stall_lo, input int stall_hi,
                            input bit rnd, output int stall_seen);
    logic [10:0] e0, e1;
    int cyc;
    stall_seen = 0;
    cyc = 0;
    while (cyc < ncyc || q0.size() > 0) begin
      @(negedge clk);
      if (cyc >= ncyc + 12) begin
        nfail++; $display("[TB] FAIL stream_drain timeout with %0d pending", q0.size());
        q0.delete(); q1.delete(); occ = 0;
        break;
      end
      in_valid  = (cyc < ncyc) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = (cyc >= ncyc) ? 1'b1 :
                  (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 :
                  (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      a  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      b  = (op == 3'd5 || op == 3'd6) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      #1;
      nchk++; if (in_ready0 !== (occ < 2 || out_ready) || in_ready1 !== in_ready0) begin nfail++; $display("[TB] FAIL stream_in_ready[%0d] got %b/%b want %b", cyc, in_ready0, in_ready1, (occ < 2 || out_ready)); end
      if (!in_ready0) stall_seen++;
      nchk++; if (out_valid1 !== out_valid0 || (out_valid0 && q0.size() == 0)) begin nfail++; $display("[TB] FAIL stream_out_valid[%0d] got %b/%b pending %0d", cyc, out_valid0, out_valid1, q0.size()); end
      if (out_valid0 && q0.size() > 0) begin
        nchk++; if ({zero0, ovf0, carry0, result0} !== q0[0]) begin nfail++; $display("[TB] FAIL stream_res0[%0d] got %h want %h", cyc, {zero0, ovf0, carry0, result0}, q0[0]); end
        nchk++; if ({zero1, ovf1, carry1, result1} !== q1[0]) begin nfail++; $display("[TB] FAIL stream_res1[%0d] got %h want %h", cyc, {zero1, ovf1, carry1, result1}, q1[0]); end
        if (out_ready) begin
          e0 = q0.pop_front(); e1 = q1.pop_front(); exp_cnt++; occ--;
        end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(model(a, b, op, 1'b0));
        q1.push_back(model(a, b, op, 1'b1));
        occ++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nchk++; if (ops_done0 !== exp_cnt[15:0] || ops_done1 !== exp_cnt[3:0]) begin nfail++; $display("[TB] FAIL stream_count got %0d/%0d want %0d", ops_done0, ops_done1, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int stalls;
    run_stream(20, 5, 10, 1'b0, stalls);
    nchk++; if (stalls != 5) begin nfail++; $display("[TB] FAIL bp_stall_cycles got %0d want 5", stalls); end
  endtask

  task automatic test_random();
    int stalls;
    run_stream(300, -1, -1, 1'b1, stalls);
  endtask

  task automatic test_reset_midflight();
    logic [10:0] e0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'd4;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nchk++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin nfail++; $display("[TB] FAIL mid_full got %b/%b want 1/0", out_valid0, in_ready0); end
    #2;
    rst = 1'b1;
    #1;
    nchk++; if (out_valid0 !== 1'b0 || ops_done0 !== 16'h0 || zero0 !== 1'b1) begin nfail++; $display("[TB] FAIL mid_reset got v%b cnt%0d z%b want v0 cnt0 z1", out_valid0, ops_done0, zero0); end
    @(negedge clk);
    rst = 1'b0;
    q0.delete(); q1.delete(); occ = 0; exp_cnt = 0;
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h3C; b = 8'h02; op = 3'd5;
    e0 = model(a, b, op, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nchk++; if (out_valid0 !== 1'b0 || ops_done0 !== 16'h0) begin nfail++; $display("[TB] FAIL mid_post1 got %b/%0d want 0/0", out_valid0, ops_done0); end
    @(negedge clk);
    #1;
    nchk++; if (out_valid0 !== 1'b1 || {zero0, ovf0, carry0, result0} !== e0) begin nfail++; $display("[TB] FAIL mid_post2 got %b/%h want 1/%h", out_valid0, {zero0, ovf0, carry0, result0}, e0); end
    @(negedge clk);
    #1;
    exp_cnt = 1;
    nchk++; if (ops_done0 !== 16'h1) begin nfail++; $display("[TB] FAIL mid_count got %0d want 1", ops_done0); end
  endtask

  task automatic test_counter_wrap();
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_valid = 1'b1; a = 8'h01; b = 8'h01; op = 3'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nchk++; if (ops_done0 !== 16'hFFFF || ops_done1 !== 4'hF) begin nfail++; $display("[TB] FAIL wrap_full got %h/%h want ffff/f", ops_done0, ops_done1); end
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; op = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    nchk++; if ({zero0, ovf0, carry0, result0} !== 11'h500 || {zero1, ovf1, carry1, result1} !== 11'h1FF) begin nfail++; $display("[TB] FAIL wrap_op got %h/%h want 500/1ff", {zero0, ovf0, carry0, result0}, {zero1, ovf1, carry1, result1}); end
    @(negedge clk);
    #1;
    nchk++; if (ops_done0 !== 16'h0 || ops_done1 !== 4'h0) begin nfail++; $display("[TB] FAIL wrap_zero got %h/%h want 0/0", ops_done0, ops_done1); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    $display("[TB] starting alu_pipe bench");
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
